fifo_sync_pack: RTL and testbench

- Single-clock FIFO that upsizes data: narrow DW_W writes are packed into wide DW_R reads.
- It performs the reverse width conversion of the team's wide-to-narrow async FIFO, so a narrow producer can feed a wide consumer.
- Storage is a ring of DW_W-wide words.
- Each read pops R = DW_R/DW_W consecutive words as one beat. The first-written word goes in the LSBs (little-endian packing).

---
 rtl/fifo_sync_pack.sv | 93 +++++++++
 tb/tb_fifo_sync_pack.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_sync_pack.sv
// Single-clock upsizing FIFO: narrow DW_W writes are packed little-endian into DW_R read beats.
// Storage is a ring of DW_W words; each read pops DW_R/DW_W consecutive words.
module fifo_sync_pack #(
  parameter int unsigned DW_W = 32,
  parameter int unsigned DW_R = 64,
  parameter int unsigned SIZE = 2048
) (
  input  logic                                             clk,
  input  logic                                             rst,
  input  logic                                             w_req,
  input  logic [DW_W-1:0]                                  data_i,
  output logic                                             full,
  input  logic                                             r_req,
  output logic [DW_R-1:0]                                  data_o,
  output logic                                             empty,
  output logic [$clog2(SIZE/(DW_W/8)):0]                   w_cnt,
  output logic [$clog2(SIZE/(DW_W/8)/(DW_R/DW_W)):0]       r_cnt,
  output logic                                             ovf,
  output logic                                             udf
);

  localparam int unsigned R   = DW_R / DW_W;
  localparam int unsigned D   = SIZE / (DW_W / 8);
  localparam int unsigned AW  = $clog2(D);
  localparam int unsigned CW  = AW + 1;
  localparam int unsigned RW  = $clog2(R);
  localparam int unsigned RCW = $clog2(D / R) + 1;

  logic [DW_W-1:0] r_mem [D];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;
  logic [DW_R-1:0] r_data;
  logic            r_ovf;
  logic            r_udf;

  logic            w_we;
  logic            w_re;
  logic [DW_R-1:0] w_beat;
  logic [CW-1:0]   w_count_next;

  assign full  = (r_count == CW'(D));
  assign empty = (r_count < CW'(R));
  assign w_cnt = r_count;
  assign r_cnt = RCW'(r_count >> RW);

  assign w_we = w_req & ~full;
  assign w_re = r_req & ~empty;

  // Pointer arithmetic is AW bits wide, so beats straddling the end of storage wrap naturally.
  always_comb begin
    w_beat = '0;
    for (int k = 0; k < int'(R); k++) begin
      w_beat[k*DW_W +: DW_W] = r_mem[r_rptr + AW'(k)];
    end
  end

  always_comb begin
    w_count_next = r_count;
    if (w_we) w_count_next = w_count_next + CW'(1);
    if (w_re) w_count_next = w_count_next - CW'(R);
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (w_we) r_mem[r_wptr] <= data_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_data  <= '0;
      r_ovf   <= 1'b0;
      r_udf   <= 1'b0;
    end else begin
      if (w_we) r_wptr <= r_wptr + AW'(1);
      if (w_re) begin
        r_rptr <= r_rptr + AW'(R);
        r_data <= w_beat;
      end
      r_count <= w_count_next;
      r_ovf   <= r_ovf | (w_req & full);
      r_udf   <= r_udf | (r_req & empty);
    end
  end

  assign data_o = r_data;
  assign ovf    = r_ovf;
  assign udf    = r_udf;

endmodule

// File: tb/tb_fifo_sync_pack.sv
// Randomized and directed bench for fifo_sync_pack (SIZE=64: D=16, R=2) against a queue model.
module tb_fifo_sync_pack;

  localparam int unsigned DW_W = 32;
  localparam int unsigned DW_R = 64;
  localparam int unsigned SIZE = 64;
  localparam int unsigned D    = 16;
  localparam int unsigned R    = 2;

  logic            clk;
  logic            rst;
  logic            w_req;
  logic [31:0]     data_i;
  logic            full;
  logic            r_req;
  logic [63:0]     data_o;
  logic            empty;
  logic [4:0]      w_cnt;
  logic [3:0]      r_cnt;
  logic            ovf;
  logic            udf;

  fifo_sync_pack #(
    .DW_W (DW_W),
    .DW_R (DW_R),
    .SIZE (SIZE)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .w_req  (w_req),
    .data_i (data_i),
    .full   (full),
    .r_req  (r_req),
    .data_o (data_o),
    .empty  (empty),
    .w_cnt  (w_cnt),
    .r_cnt  (r_cnt),
    .ovf    (ovf),
    .udf    (udf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a queue of stored words plus the last popped beat and sticky flags.
  logic [31:0] m_q[$];
  logic [63:0] m_data;
  logic        m_ovf;
  logic        m_udf;

  int n_vec;
  int n_err;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_data = '0;
    m_ovf  = 1'b0;
    m_udf  = 1'b0;
  endtask

  task automatic check_all(input string tag);
    int sz;
    sz = m_q.size();
    check({tag, ".w_cnt"}, 64'(w_cnt), 64'(sz));
    check({tag, ".r_cnt"}, 64'(r_cnt), 64'(sz / int'(R)));
    check({tag, ".full"},  64'(full),  64'(sz == int'(D)));
    check({tag, ".empty"}, 64'(empty), 64'(sz < int'(R)));
    check({tag, ".data_o"}, data_o, m_data);
    check({tag, ".ovf"},   64'(ovf),   64'(m_ovf));
    check({tag, ".udf"},   64'(udf),   64'(m_udf));
  endtask

  // One clock: drive, take the edge, update the model from pre-edge state, then check.
  task automatic step(input logic w, input logic r, input logic [31:0] d, input string tag);
    bit m_full;
    bit m_empty;
    logic [31:0] lo;
    logic [31:0] hi;
    w_req  = w;
    r_req  = r;
    data_i = w ? d : 'x;
    @(posedge clk);
    m_full  = (m_q.size() == int'(D));
    m_empty = (m_q.size() < int'(R));
    if (w && m_full)  m_ovf = 1'b1;
    if (r && m_empty) m_udf = 1'b1;
    if (r && !m_empty) begin
      lo = m_q.pop_front();
      hi = m_q.pop_front();
      m_data = {hi, lo};
    end
    if (w && !m_full) m_q.push_back(d);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    model_reset();
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    n_vec  = 0;
    n_err  = 0;
    rst    = 1'b1;
    w_req  = 1'b0;
    r_req  = 1'b0;
    data_i = '0;
    model_reset();
    #12;
    check_all("por");
    @(negedge clk);
    rst = 1'b0;

    // Basic pack
    step(1'b1, 1'b0, 32'h1111_1111, "wr1");
    step(1'b1, 1'b0, 32'h2222_2222, "wr2");
    step(1'b0, 1'b1, 32'h0, "rd1");
    check("pack_const", data_o, 64'h2222_2222_1111_1111);

    // Fill, overflow, drain
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 32'(i), "fill");
    step(1'b1, 1'b0, 32'hdead_beef, "ovf_wr");
    check("ovf_const", 64'(ovf), 64'd1);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 32'h0, "drain");
      check("drain_const", data_o, {32'(2*i+1), 32'(2*i)});
    end

    // Read with one word plus same-edge write: read dropped
    do_reset();
    step(1'b1, 1'b0, 32'haaaa_0001, "one");
    step(1'b1, 1'b1, 32'haaaa_0002, "udf_rw");
    check("udf_const", 64'(udf), 64'd1);

    // Full with same-edge read and write: write dropped
    do_reset();
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 32'h100 + 32'(i), "fill2");
    step(1'b1, 1'b1, 32'hbad0_0000, "full_rw");
    check("full_rw_cnt", 64'(w_cnt), 64'd14);

    // Steady stream across pointer wrap
    do_reset();
    for (int i = 0; i < 40; i++) step(1'b1, 1'b1, 32'(i), "stream");
    for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 32'h0, "stream_tail");

    // Asynchronous reset mid-stream with 7 words stored
    do_reset();
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 32'h700 + 32'(i), "pre_arst");
    step(1'b0, 1'b1, 32'h0, "pre_arst_rd");
    step(1'b1, 1'b0, 32'h707, "pre_arst2");
    step(1'b1, 1'b0, 32'h708, "pre_arst3");
    check("arst_pre_cnt", 64'(w_cnt), 64'd7);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all("arst");
    check("arst_data", data_o, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 1'b0, 32'h0000_000a, "post_a");
    step(1'b1, 1'b0, 32'h0000_000b, "post_b");
    step(1'b0, 1'b1, 32'h0, "post_rd");
    check("post_const", data_o, 64'h0000_000b_0000_000a);

    // Random traffic with shifting write/read bias
    do_reset();
    for (int i = 0; i < 600; i++) begin
      int bias;
      bias = (i / 100) % 3;
      step(($urandom_range(0, 3) < (bias == 0 ? 3 : 1)) ? 1'b1 : 1'b0,
           ($urandom_range(0, 3) < (bias == 1 ? 3 : 2)) ? 1'b1 : 1'b0,
           $urandom, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
